// File: rtl/uart_tx_unit.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// txd and busy are registered from the current FSM state, so they lag the state by one clock.
module uart_tx_unit #(
  parameter int unsigned BIT_PERIOD = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       vld_tx,
  output logic       rdy_tx,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] TickMax = 16'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  state_e          r_state;
  logic [15:0]     r_tick;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic            r_busy;

  state_e          w_state_nxt;
  logic [15:0]     w_tick_nxt;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      w_shift_nxt;
  logic            w_txd_nxt;
  logic            w_busy_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_tick_done;
  logic            w_not_empty;
  logic [7:0]      w_head;

  // Readiness depends only on the registered count; a pop in the same cycle never frees a slot.
  assign rdy_tx      = (r_count != FullCnt);
  assign w_push      = vld_tx & rdy_tx;
  assign w_not_empty = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_tick_done = (r_tick == TickMax);

  assign txd  = r_txd;
  assign busy = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      StIdle: begin
        w_tick_nxt = '0;
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_bit_nxt   = '0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (w_tick_done) begin
          w_tick_nxt  = '0;
          w_state_nxt = StData;
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      StData: begin
        if (w_tick_done) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = StStop;
          end
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      StStop: begin
        if (w_tick_done) begin
          w_tick_nxt = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_bit_nxt   = '0;
            w_state_nxt = StStart;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tick_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    case (r_state)
      StStart: w_txd_nxt = 1'b0;
      StData:  w_txd_nxt = r_shift[0];
      default: w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (r_state != StIdle) | w_not_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: cycle-level reference model plus a serial-line decoder
// that checks received frames against a scoreboard of accepted bytes.
module tb_uart_tx_unit;

  localparam int BP    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       vld_tx = 1'b0;
  logic       rdy_tx;
  logic       txd;
  logic       busy;

  uart_tx_unit #(
    .BIT_PERIOD(BP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .vld_tx(vld_tx),
    .rdy_tx(rdy_tx),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: buffered bytes, frame in flight, and the edge it started on.
  logic [7:0] m_q[$];
  logic [7:0] sb_q[$];
  bit         m_active = 1'b0;
  int         m_p = 0;
  logic [7:0] m_cur = 8'h00;
  int         cyc = 0;
  logic       m_txd = 1'b1;
  logic       m_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge. A frame popped at edge P occupies
  // edges P..P+FRAME; txd shows the slot of the cycle just ended.
  task automatic model_edge(input bit acc, input logic [7:0] d);
    int k;
    int slot;
    cyc++;
    m_busy = m_active || (m_q.size() != 0);
    m_txd  = 1'b1;
    if (m_active) begin
      k    = cyc - m_p;
      slot = (k - 1) / BP;
      if (slot == 0) m_txd = 1'b0;
      else if (slot <= 8) m_txd = m_cur[3'(slot - 1)];
    end
    if (!m_active && m_q.size() != 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_p      = cyc;
    end else if (m_active && (cyc - m_p) == FRAME) begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_p   = cyc;
      end else begin
        m_active = 1'b0;
      end
    end
    if (acc) begin
      m_q.push_back(d);
      sb_q.push_back(d);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d);
    bit acc;
    chk("rdy_tx", 32'(rdy_tx), 32'(m_q.size() < DEPTH));
    vld_tx = v;
    din    = d;
    acc    = v && (m_q.size() < DEPTH);
    @(posedge clk);
    model_edge(acc, d);
    @(negedge clk);
    vld_tx = 1'b0;
    chk("txd", 32'(txd), 32'(m_txd));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_txd", 32'(txd), 32'd1);
    chk("rst_async_rdy", 32'(rdy_tx), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    m_q.delete();
    sb_q.delete();
    m_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold_txd", 32'(txd), 32'd1);
    chk("rst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  // Line decoder: samples mid-bit, independent of the stimulus process.
  bit         mon_on = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (txd == 1'b0) begin
        mon_on   = 1'b1;
        mon_cnt  = 0;
        mon_byte = 8'h00;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 8) begin
        chk("start_bit", 32'(txd), 32'd0);
      end else if (mon_cnt >= 24 && mon_cnt <= 136 && ((mon_cnt - 8) % 16) == 0) begin
        mon_byte[3'((mon_cnt - 24) / 16)] = txd;
      end else if (mon_cnt == 152) begin
        chk("stop_bit", 32'(txd), 32'd1);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_byte: got unexpected frame %0h expected none at %0t",
                   mon_byte, $time);
        end else begin
          chk("frame_byte", 32'(mon_byte), 32'(sb_q.pop_front()));
        end
        mon_on = 1'b0;
      end
    end
  end

  initial begin
    int pct;
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_rdy", 32'(rdy_tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) step(1'b0, 8'h00);

    // Single byte from idle: latency and busy fall.
    step(1'b1, 8'h55);
    step(1'b0, 8'h00);
    chk("lat_n1_txd", 32'(txd), 32'd1);
    step(1'b0, 8'h00);
    chk("lat_n2_txd", 32'(txd), 32'd0);
    for (int k = 3; k <= 170; k++) begin
      step(1'b0, 8'h00);
      if (k == 161) chk("busy_n161", 32'(busy), 32'd1);
      if (k == 162) chk("busy_n162", 32'(busy), 32'd0);
    end

    // Two consecutive writes, back-to-back frames.
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    repeat (340) step(1'b0, 8'h00);

    // Six writes with vld held: the sixth finds the FIFO full.
    for (int i = 1; i <= 6; i++) begin
      chk("fill_rdy", 32'(rdy_tx), 32'(i <= 5));
      step(1'b1, 8'(i));
    end
    repeat (5 * FRAME + 20) step(1'b0, 8'h00);

    // Abort during bit 3 of 0xFF with two bytes buffered.
    step(1'b1, 8'hFF);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    repeat (72) step(1'b0, 8'h00);
    do_reset();
    repeat (200) step(1'b0, 8'h00);

    // Abort during a start bit, where txd must visibly jump high.
    step(1'b1, 8'h00);
    repeat (5) step(1'b0, 8'h00);
    chk("pre_abort_txd", 32'(txd), 32'd0);
    do_reset();
    repeat (30) step(1'b0, 8'h00);

    // Write on the edge where STOP ends and pops the last buffered byte.
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    repeat (159) step(1'b0, 8'h00);
    step(1'b1, 8'hC3);
    repeat (2 * FRAME + 20) step(1'b0, 8'h00);

    // Write on the edge where STOP ends with the FIFO empty.
    step(1'b1, 8'hD1);
    repeat (160) step(1'b0, 8'h00);
    step(1'b1, 8'hD2);
    repeat (FRAME + 20) step(1'b0, 8'h00);

    // Random traffic with varying write density.
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 2))
        0:       pct = 3;
        1:       pct = 30;
        default: pct = 90;
      endcase
      repeat (100) step($urandom_range(0, 99) < pct, 8'($urandom));
    end

    guard = 0;
    while ((m_active || m_q.size() != 0) && guard < 2000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    repeat (20) step(1'b0, 8'h00);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
